// File: rtl/rf_arb_pkg.sv
// Shared constants and buffer-entry type for the register-file write arbiter.
package rf_arb_pkg;

    localparam int NREG = 32;
    localparam int DW = 32;
    localparam int REG_W = 5;
    localparam logic [REG_W-1:0] ZERO_REG = '0;

    typedef struct packed {
        logic full;
        logic [REG_W-1:0] regNum;
        logic [DW-1:0] data;
    } wb_entry_t;

endpackage

// File: rtl/wb_buffer.sv
// One-entry writeback holding buffer with valid/ready handshake.
// An entry aimed at $zero drops itself at the next edge without a grant.
module wb_buffer
    import rf_arb_pkg::*;
(
    input  logic             clk,
    input  logic             reset,
    input  logic             inValid,
    output logic             inReady,
    input  logic [REG_W-1:0] inReg,
    input  logic [DW-1:0]    inData,
    input  logic             grant,
    output logic             load,
    output logic             full,
    output logic [REG_W-1:0] regNum,
    output logic [DW-1:0]    data
);

    wb_entry_t entry;

    assign inReady = ~entry.full | grant;
    assign load    = inValid & inReady;
    assign full    = entry.full;
    assign regNum  = entry.regNum;
    assign data    = entry.data;

    always_ff @(posedge clk) begin
        if (reset) begin
            entry <= '0;
        end else if (load) begin
            entry.full   <= 1'b1;
            entry.regNum <= inReg;
            entry.data   <= inData;
        end else if (grant || entry.regNum == ZERO_REG) begin
            entry.full <= 1'b0;
        end
    end

endmodule

// File: rtl/rf_write_arbiter.sv
// Arbitrates two writeback buffers onto the single register-file write port
// and tracks pending writes. Define RF_ARB_RR_EN for round-robin policy ties.
module rf_write_arbiter #(
    parameter int NREG = 32,
    parameter int DW   = 32
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            req0_valid,
    output logic            req0_ready,
    input  logic [4:0]      req0_reg,
    input  logic [DW-1:0]   req0_data,
    input  logic            req1_valid,
    output logic            req1_ready,
    input  logic [4:0]      req1_reg,
    input  logic [DW-1:0]   req1_data,
    output logic [4:0]      writeReg,
    output logic [DW-1:0]   writeData,
    output logic            regWrite,
    output logic [NREG-1:0] pending
);
    import rf_arb_pkg::*;

    logic             full0, full1, load0, load1, grant0, grant1;
    logic             cand0, cand1, pick1, age1Older;
    logic [REG_W-1:0] reg0q, reg1q;
    logic [DW-1:0]    data0q, data1q;
    logic [NREG-1:0]  pendingNext;

    wb_buffer u_buf0 (
        .clk(clk), .reset(reset), .inValid(req0_valid), .inReady(req0_ready),
        .inReg(req0_reg), .inData(req0_data), .grant(grant0), .load(load0),
        .full(full0), .regNum(reg0q), .data(data0q)
    );

    wb_buffer u_buf1 (
        .clk(clk), .reset(reset), .inValid(req1_valid), .inReady(req1_ready),
        .inReg(req1_reg), .inData(req1_data), .grant(grant1), .load(load1),
        .full(full1), .regNum(reg1q), .data(data1q)
    );

`ifdef RF_ARB_RR_EN
    logic rrPtr;

    // Pointer flips away from whichever side won a two-candidate grant.
    always_ff @(posedge clk) begin
        if (reset)
            rrPtr <= 1'b0;
        else if (cand0 && cand1)
            rrPtr <= grant0;
    end
`endif

    always_comb begin
        cand0  = ~reset & full0 & (reg0q != ZERO_REG);
        cand1  = ~reset & full1 & (reg1q != ZERO_REG);
        grant0 = 1'b0;
        grant1 = 1'b0;
        pick1  = 1'b0;
        if (cand0 && !cand1) begin
            grant0 = 1'b1;
        end else if (cand1 && !cand0) begin
            grant1 = 1'b1;
        end else if (cand0 && cand1) begin
            if (reg0q == reg1q)
                pick1 = age1Older;
            else
`ifdef RF_ARB_RR_EN
                pick1 = rrPtr;
`else
                pick1 = 1'b0;
`endif
            grant0 = ~pick1;
            grant1 = pick1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset)
            age1Older <= 1'b0;
        else if (load0 && full1 && !grant1)
            age1Older <= 1'b1;
        else if (load1 && full0 && !grant0)
            age1Older <= 1'b0;
    end

    always_comb begin
        regWrite  = grant0 | grant1;
        writeReg  = '0;
        writeData = '0;
        if (grant0) begin
            writeReg  = reg0q;
            writeData = data0q;
        end else if (grant1) begin
            writeReg  = reg1q;
            writeData = data1q;
        end
    end

    // A committed reg stays pending while the non-granted buffer still targets it.
    always_comb begin
        pendingNext = pending;
        if (regWrite && !(grant0 ? (full1 && reg1q == writeReg)
                                 : (full0 && reg0q == writeReg)))
            pendingNext[writeReg] = 1'b0;
        if (load0)
            pendingNext[req0_reg] = 1'b1;
        if (load1)
            pendingNext[req1_reg] = 1'b1;
        pendingNext[ZERO_REG] = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (reset)
            pending <= '0;
        else
            pending <= pendingNext;
    end

endmodule
